// File: rtl/minisrc_system.sv
// Mini-SRC single-bus datapath with 512x32 memory; every control strobe is driven
// from outside, so the enclosing bench or sequencer supplies the T-state controls.
module minisrc_system #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] inport_data,
    input  logic                  inport_data_ready,
    output logic [DATA_WIDTH-1:0] outport_data,
    input  logic                  HIout,
    input  logic                  LOout,
    input  logic                  Zhi_out,
    input  logic                  Zlo_out,
    input  logic                  PCout,
    input  logic                  MDRout,
    input  logic                  Inport_out,
    input  logic                  Cout,
    input  logic                  MARin,
    input  logic                  Zin,
    input  logic                  PCin,
    input  logic                  MDRin,
    input  logic                  IRin,
    input  logic                  Yin,
    input  logic                  HIin,
    input  logic                  LOin,
    input  logic                  outport_in,
    input  logic [4:0]            opcode,
    input  logic                  IncPC,
    input  logic                  Gra,
    input  logic                  Grb,
    input  logic                  Grc,
    input  logic                  Rin,
    input  logic                  Rout,
    input  logic                  BAout,
    output logic                  con_ff_bit,
    input  logic                  Mem_Read,
    input  logic                  Mem_Write,
    input  logic                  Mem_enable512x32,
    output logic [DATA_WIDTH-1:0] Mem_to_datapath_out,
    output logic [DATA_WIDTH-1:0] Mem_data_to_chip_out,
    output logic [ADDR_WIDTH-1:0] MAR_address_out,
    input  logic                  mem_overide,
    input  logic [ADDR_WIDTH-1:0] overide_address,
    input  logic [DATA_WIDTH-1:0] overide_data_in
);

    localparam int DW        = DATA_WIDTH;
    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam int SHW       = $clog2(DW);
    localparam logic [DW-1:0]  ZERO_C = {DW{1'b0}};
    localparam logic [DW-1:0]  ONE_C  = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [SHW:0]   DW_C   = (SHW+1)'(DW);

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;

    logic [DW-1:0]         regs_r [0:15];
    logic [DW-1:0]         mem_r  [0:MEM_DEPTH-1];
    logic [DW-1:0]         pc_r, ir_r, mdr_r, y_r, hi_r, lo_r, inport_r, outport_r;
    logic [2*DW-1:0]       z_r;
    logic [ADDR_WIDTH-1:0] mar_r;
    logic                  con_r;

    logic [DW-1:0]   bus_s, mem_rd_s, c_ext_s;
    logic [3:0]      ra_s, rb_s, rc_s, sel_s;
    logic [2*DW-1:0] alu_s, a_ext_s, b_ext_s, prod_s;
    logic [DW-1:0]   ror_s, rol_s, quot_s, rem_s;
    logic [SHW-1:0]  amt_s;
    logic [SHW:0]    ramt_s;
    logic            cond_s;
    logic            unused_ir_op_s;

    assign ra_s    = ir_r[26:23];
    assign rb_s    = ir_r[22:19];
    assign rc_s    = ir_r[18:15];
    assign c_ext_s = {{(DW-19){ir_r[18]}}, ir_r[18:0]};
    assign sel_s   = ({4{Gra}} & ra_s) | ({4{Grb}} & rb_s) | ({4{Grc}} & rc_s);
    // The opcode field is decoded by the external control, never inside the datapath.
    assign unused_ir_op_s = ^ir_r[DW-1:DW-5];

    assign mem_rd_s = (Mem_enable512x32 && Mem_Read) ? mem_r[mar_r] : ZERO_C;

    // Bus source selection with fixed priority when controls overlap.
    always_comb begin
        bus_s = ZERO_C;
        if (Rout) begin
            bus_s = regs_r[sel_s];
        end else if (BAout) begin
            bus_s = (sel_s == 4'd0) ? ZERO_C : regs_r[sel_s];
        end else if (HIout) begin
            bus_s = hi_r;
        end else if (LOout) begin
            bus_s = lo_r;
        end else if (Zhi_out) begin
            bus_s = z_r[2*DW-1:DW];
        end else if (Zlo_out) begin
            bus_s = z_r[DW-1:0];
        end else if (PCout) begin
            bus_s = pc_r;
        end else if (MDRout) begin
            bus_s = mdr_r;
        end else if (Inport_out) begin
            bus_s = inport_r;
        end else if (Cout) begin
            bus_s = c_ext_s;
        end else begin
            bus_s = ZERO_C;
        end
    end

    // ALU: A comes from Y, B from the bus; result is the 64-bit value for Z.
    always_comb begin
        alu_s   = {(2*DW){1'b0}};
        quot_s  = ZERO_C;
        rem_s   = ZERO_C;
        amt_s   = bus_s[SHW-1:0];
        ramt_s  = DW_C - {1'b0, amt_s};
        ror_s   = (y_r >> amt_s) | (y_r << ramt_s);
        rol_s   = (y_r << amt_s) | (y_r >> ramt_s);
        a_ext_s = {{DW{y_r[DW-1]}}, y_r};
        b_ext_s = {{DW{bus_s[DW-1]}}, bus_s};
        prod_s  = a_ext_s * b_ext_s;
        if (IncPC) begin
            alu_s = {ZERO_C, bus_s + ONE_C};
        end else begin
            case (opcode)
                OP_ADD, OP_ADDI: alu_s = {ZERO_C, y_r + bus_s};
                OP_SUB:          alu_s = {ZERO_C, y_r - bus_s};
                OP_AND, OP_ANDI: alu_s = {ZERO_C, y_r & bus_s};
                OP_OR, OP_ORI:   alu_s = {ZERO_C, y_r | bus_s};
                OP_ROR:          alu_s = {ZERO_C, ror_s};
                OP_ROL:          alu_s = {ZERO_C, rol_s};
                OP_SHR:          alu_s = {ZERO_C, y_r >> amt_s};
                OP_SHRA:         alu_s = {ZERO_C, $signed(y_r) >>> amt_s};
                OP_SHL:          alu_s = {ZERO_C, y_r << amt_s};
                OP_MUL:          alu_s = prod_s;
                OP_DIV: begin
                    if (bus_s == ZERO_C) begin
                        alu_s = {(2*DW){1'b0}};
                    end else begin
                        quot_s = $signed(y_r) / $signed(bus_s);
                        rem_s  = $signed(y_r) % $signed(bus_s);
                        alu_s  = {rem_s, quot_s};
                    end
                end
                OP_NEG:          alu_s = {ZERO_C, ZERO_C - bus_s};
                OP_NOT:          alu_s = {ZERO_C, ~bus_s};
                default:         alu_s = {ZERO_C, y_r + bus_s};
            endcase
        end
    end

    // Branch condition selected by IR[20:19], evaluated on the bus value.
    always_comb begin
        case (ir_r[20:19])
            2'b00:   cond_s = (bus_s == ZERO_C);
            2'b01:   cond_s = (bus_s != ZERO_C);
            2'b10:   cond_s = !bus_s[DW-1] && (bus_s != ZERO_C);
            2'b11:   cond_s = bus_s[DW-1];
            default: cond_s = 1'b0;
        endcase
    end

    // Special-purpose registers; clear wins over every load.
    always_ff @(posedge Clock) begin
        if (clear) begin
            pc_r      <= ZERO_C;
            ir_r      <= ZERO_C;
            mar_r     <= {ADDR_WIDTH{1'b0}};
            mdr_r     <= ZERO_C;
            y_r       <= ZERO_C;
            z_r       <= {(2*DW){1'b0}};
            hi_r      <= ZERO_C;
            lo_r      <= ZERO_C;
            inport_r  <= ZERO_C;
            outport_r <= ZERO_C;
            con_r     <= 1'b0;
        end else begin
            if (PCin)              pc_r      <= bus_s;
            if (IRin)              ir_r      <= bus_s;
            if (MARin)             mar_r     <= bus_s[ADDR_WIDTH-1:0];
            if (MDRin)             mdr_r     <= Mem_Read ? mem_rd_s : bus_s;
            if (Yin)               y_r       <= bus_s;
            if (Zin)               z_r       <= alu_s;
            if (HIin)              hi_r      <= bus_s;
            if (LOin)              lo_r      <= bus_s;
            if (inport_data_ready) inport_r  <= inport_data;
            if (outport_in)        outport_r <= bus_s;
            if ((opcode == OP_BR) && Rout) con_r <= cond_s;
        end
    end

    // General register file R0-R15; R0 is writable, only BAout masks it.
    always_ff @(posedge Clock) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= ZERO_C;
            end
        end else if (Rin) begin
            regs_r[sel_s] <= bus_s;
        end
    end

    // Memory array keeps its contents through clear; the override port is written last so it wins.
    always_ff @(posedge Clock) begin
        if (Mem_enable512x32 && Mem_Write) begin
            mem_r[mar_r] <= mdr_r;
        end
        if (mem_overide) begin
            mem_r[overide_address] <= overide_data_in;
        end
    end

    assign outport_data         = outport_r;
    assign con_ff_bit           = con_r;
    assign Mem_to_datapath_out  = mem_rd_s;
    assign Mem_data_to_chip_out = mdr_r;
    assign MAR_address_out      = mar_r;

endmodule

// File: tb/tb_minisrc_system.sv
// Directed program-level checks of minisrc_system plus randomized ALU checks
// against an arithmetic reference model.
module tb_minisrc_system;

    logic        Clock = 1'b0;
    logic        clear;
    logic [31:0] inport_data;
    logic        inport_data_ready;
    logic [31:0] outport_data;
    logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in;
    logic [4:0]  opcode;
    logic        IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
    logic        con_ff_bit;
    logic        Mem_Read, Mem_Write, Mem_enable512x32;
    logic [31:0] Mem_to_datapath_out, Mem_data_to_chip_out;
    logic [8:0]  MAR_address_out;
    logic        mem_overide;
    logic [8:0]  overide_address;
    logic [31:0] overide_data_in;

    int n_assert = 0;
    int n_fail   = 0;

    minisrc_system dut (
        .Clock(Clock), .clear(clear),
        .inport_data(inport_data), .inport_data_ready(inport_data_ready),
        .outport_data(outport_data),
        .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
        .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
        .Yin(Yin), .HIin(HIin), .LOin(LOin), .outport_in(outport_in),
        .opcode(opcode), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .con_ff_bit(con_ff_bit),
        .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32),
        .Mem_to_datapath_out(Mem_to_datapath_out),
        .Mem_data_to_chip_out(Mem_data_to_chip_out),
        .MAR_address_out(MAR_address_out),
        .mem_overide(mem_overide), .overide_address(overide_address),
        .overide_data_in(overide_data_in)
    );

    always #5 Clock = ~Clock;

    task automatic clr_ctrl();
        inport_data_ready = 1'b0;
        {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout} = 8'd0;
        {MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in} = 9'd0;
        opcode = 5'd0;
        {IncPC, Gra, Grb, Grc, Rin, Rout, BAout} = 7'd0;
        {Mem_Read, Mem_Write, Mem_enable512x32} = 3'd0;
        mem_overide = 1'b0;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
        clr_ctrl();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put_inport(input logic [31:0] v);
        inport_data = v;
        inport_data_ready = 1'b1;
        step();
    endtask

    task automatic ovr(input logic [8:0] addr, input logic [31:0] data);
        mem_overide = 1'b1;
        overide_address = addr;
        overide_data_in = data;
        step();
    endtask

    task automatic fetch(input logic [8:0] exp_mar, input logic [31:0] exp_word);
        PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1;
        step();
        check("fetch_mar", 64'(MAR_address_out), 64'(exp_mar));
        Zlo_out = 1'b1; PCin = 1'b1; MDRin = 1'b1; Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
        step();
        check("fetch_mdr", 64'(Mem_data_to_chip_out), 64'(exp_word));
        MDRout = 1'b1; IRin = 1'b1;
        step();
    endtask

    task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic inc, output logic [31:0] lo, output logic [31:0] hi);
        put_inport(a);
        Inport_out = 1'b1; Yin = 1'b1; inport_data = b; inport_data_ready = 1'b1;
        step();
        Inport_out = 1'b1; opcode = op; IncPC = inc; Zin = 1'b1;
        step();
        Zlo_out = 1'b1; outport_in = 1'b1;
        step();
        lo = outport_data;
        Zhi_out = 1'b1; outport_in = 1'b1;
        step();
        hi = outport_data;
    endtask

    // Reference ALU computed with plain 64-bit integer arithmetic.
    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic inc);
        longint sa, sb, ua, ub, r;
        int n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        n  = int'(b[4:0]);
        if (inc) return {32'd0, 32'(ub + 64'sd1)};
        case (op)
            5'd3, 5'd12:  r = ua + ub;
            5'd4:         r = ua - ub;
            5'd5, 5'd13:  r = ua & ub;
            5'd6, 5'd14:  r = ua | ub;
            5'd7:         r = (ua >> n) | (ua << (32 - n));
            5'd8:         r = (ua << n) | (ua >> (32 - n));
            5'd9:         r = ua >> n;
            5'd10:        r = sa >>> n;
            5'd11:        r = ua << n;
            5'd15:        return 64'(sa * sb);
            5'd16: begin
                if (sb == 64'sd0) return 64'd0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            5'd17:        r = -sb;
            5'd18:        r = ~ub;
            default:      r = ua + ub;
        endcase
        return {32'd0, 32'(r)};
    endfunction

    logic [31:0] lo_v, hi_v, ra_v, rb_v;
    logic [4:0]  op_v;
    logic        inc_v;
    logic [63:0] exp_v;

    initial begin
        clr_ctrl();
        inport_data = 32'd0;
        overide_address = 9'd0;
        overide_data_in = 32'd0;
        clear = 1'b1;
        step();
        // Program preload through the override port while still in reset.
        ovr(9'd0,   32'h18900001);
        ovr(9'd500, 32'h00000014);
        ovr(9'd1,   32'h03000000);
        ovr(9'd2,   32'h03B00000);
        clear = 1'b0;

        check("rst_outport", 64'(outport_data), 64'd0);
        check("rst_con",     64'(con_ff_bit), 64'd0);
        check("rst_mar",     64'(MAR_address_out), 64'd0);
        check("rst_mdr",     64'(Mem_data_to_chip_out), 64'd0);
        check("rst_memout",  64'(Mem_to_datapath_out), 64'd0);
        PCout = 1'b1; outport_in = 1'b1;
        step();
        check("rst_pc", 64'(outport_data), 64'd0);

        // Combinational memory reads.
        put_inport(32'd500);
        Inport_out = 1'b1; MARin = 1'b1;
        step();
        check("mar_500", 64'(MAR_address_out), 64'd500);
        Mem_enable512x32 = 1'b1; Mem_Read = 1'b1;
        #1;
        check("mem_500", 64'(Mem_to_datapath_out), 64'h14);
        Mem_Read = 1'b0;
        #1;
        check("mem_noread", 64'(Mem_to_datapath_out), 64'd0);
        clr_ctrl();
        PCout = 1'b1; MARin = 1'b1;
        step();
        Mem_enable512x32 = 1'b1; Mem_Read = 1'b1;
        #1;
        check("mem_0", 64'(Mem_to_datapath_out), 64'h18900001);
        clr_ctrl();

        // First fetch from reset.
        fetch(9'd0, 32'h18900001);
        Cout = 1'b1; outport_in = 1'b1;
        step();
        check("ir_cfield", 64'(outport_data), 64'd1);
        PCout = 1'b1; outport_in = 1'b1;
        step();
        check("pc_after_f1", 64'(outport_data), 64'd1);

        // Branch condition (IR[20:19]=10: bus > 0) on R1 via Ra.
        put_inport(32'd5);
        Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        step();
        Gra = 1'b1; Rout = 1'b1; opcode = 5'b10011;
        step();
        check("con_pos", 64'(con_ff_bit), 64'd1);
        Inport_out = 1'b1; opcode = 5'b10011;
        step();
        check("con_hold", 64'(con_ff_bit), 64'd1);
        put_inport(32'd0);
        Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        step();
        Gra = 1'b1; Rout = 1'b1; opcode = 5'b10011;
        step();
        check("con_zero", 64'(con_ff_bit), 64'd0);
        put_inport(32'h7FFFFFFF);
        Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        step();
        Gra = 1'b1; Rout = 1'b1; opcode = 5'b10011;
        step();
        check("con_maxpos", 64'(con_ff_bit), 64'd1);
        put_inport(32'h80000000);
        Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        step();
        Gra = 1'b1; Rout = 1'b1; opcode = 5'b10011;
        step();
        check("con_neg", 64'(con_ff_bit), 64'd0);

        // R0 is writable but BAout masks it to zero.
        put_inport(32'h55);
        Inport_out = 1'b1; Rin = 1'b1;
        step();
        Rout = 1'b1; outport_in = 1'b1;
        step();
        check("r0_rout", 64'(outport_data), 64'h55);
        BAout = 1'b1; outport_in = 1'b1;
        step();
        check("r0_baout", 64'(outport_data), 64'd0);

        // mfhi r6.
        put_inport(32'h1234);
        Inport_out = 1'b1; HIin = 1'b1;
        step();
        fetch(9'd1, 32'h03000000);
        Gra = 1'b1; HIout = 1'b1; Rin = 1'b1;
        step();
        Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1;
        step();
        check("mfhi_r6", 64'(outport_data), 64'h1234);
        PCout = 1'b1; outport_in = 1'b1;
        step();
        check("pc_after_f2", 64'(outport_data), 64'd2);

        // mflo r7 (Rb field of this word selects R6).
        put_inport(32'hABCD);
        Inport_out = 1'b1; LOin = 1'b1;
        step();
        fetch(9'd2, 32'h03B00000);
        Gra = 1'b1; LOout = 1'b1; Rin = 1'b1;
        step();
        Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1;
        step();
        check("mflo_r7", 64'(outport_data), 64'hABCD);
        Grb = 1'b1; Rout = 1'b1; outport_in = 1'b1;
        step();
        check("r6_kept", 64'(outport_data), 64'h1234);

        // Directed mul/div.
        alu_run(5'b01111, 32'hFFFFFFFD, 32'd5, 1'b0, lo_v, hi_v);
        check("mul_lo", 64'(lo_v), 64'hFFFFFFF1);
        check("mul_hi", 64'(hi_v), 64'hFFFFFFFF);
        alu_run(5'b10000, 32'd20, 32'd6, 1'b0, lo_v, hi_v);
        check("div_lo", 64'(lo_v), 64'd3);
        check("div_hi", 64'(hi_v), 64'd2);
        alu_run(5'b10000, 32'd7, 32'd0, 1'b0, lo_v, hi_v);
        check("div0", {hi_v, lo_v}, 64'd0);

        // Randomized ALU operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            op_v  = 5'($urandom_range(0, 31));
            ra_v  = $urandom;
            rb_v  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            inc_v = ($urandom_range(0, 7) == 0);
            if (op_v == 5'b10000 && ra_v == 32'h80000000 && rb_v == 32'hFFFFFFFF) rb_v = 32'd3;
            exp_v = alu_ref(op_v, ra_v, rb_v, inc_v);
            alu_run(op_v, ra_v, rb_v, inc_v, lo_v, hi_v);
            check($sformatf("alu_op%0d_lo", op_v), 64'(lo_v), 64'(exp_v[31:0]));
            check($sformatf("alu_op%0d_hi", op_v), 64'(hi_v), 64'(exp_v[63:32]));
        end

        // clear in the middle of activity, with loads asserted in the same cycle.
        put_inport(32'd9);
        Inport_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
        step();
        Gra = 1'b1; Rout = 1'b1; opcode = 5'b10011; outport_in = 1'b1;
        step();
        check("pre_clr_con", 64'(con_ff_bit), 64'd1);
        check("pre_clr_out", 64'(outport_data), 64'd9);
        clear = 1'b1;
        Inport_out = 1'b1; PCin = 1'b1; outport_in = 1'b1; MARin = 1'b1; MDRin = 1'b1;
        step();
        clear = 1'b0;
        check("clr_outport", 64'(outport_data), 64'd0);
        check("clr_con",     64'(con_ff_bit), 64'd0);
        check("clr_mar",     64'(MAR_address_out), 64'd0);
        check("clr_mdr",     64'(Mem_data_to_chip_out), 64'd0);
        Rout = 1'b1; outport_in = 1'b1;
        step();
        check("clr_r0", 64'(outport_data), 64'd0);
        PCout = 1'b1; outport_in = 1'b1;
        step();
        check("clr_pc", 64'(outport_data), 64'd0);
        HIout = 1'b1; outport_in = 1'b1;
        step();
        check("clr_hi", 64'(outport_data), 64'd0);
        Zlo_out = 1'b1; outport_in = 1'b1;
        step();
        check("clr_zlo", 64'(outport_data), 64'd0);
        put_inport(32'h03000000);
        Inport_out = 1'b1; IRin = 1'b1;
        step();
        Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1;
        step();
        check("clr_r6", 64'(outport_data), 64'd0);
        put_inport(32'd500);
        Inport_out = 1'b1; MARin = 1'b1;
        step();
        Mem_enable512x32 = 1'b1; Mem_Read = 1'b1;
        #1;
        check("mem_kept_500", 64'(Mem_to_datapath_out), 64'h14);
        clr_ctrl();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/minisrc_system.md
Name: minisrc_system

Overview:
- 32-bit single-bus datapath for a Mini-SRC-style processor, plus its 512x32 memory.
- All control signals come from outside; the block has no internal control unit.
- Testbenches drive the T-states directly, and a memory override port preloads programs and data.

Parameters:
- DATA_WIDTH, 32, width of the bus, registers and memory words.
- ADDR_WIDTH, 9, memory address width (512 words).

Ports:
- Clock  in  1  sole clock; everything updates on the rising edge.
- clear  in  1  synchronous active-high reset.
- inport_data  in  32  external input-port data.
- inport_data_ready  in  1  inport register loads inport_data.
- outport_data  out  32  output-port register.
- HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  in  1 each  bus-drive selects.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, outport_in  in  1 each  register load enables.
- opcode  in  5  ALU operation.
- IncPC  in  1  ALU computes bus+1, ignoring opcode.
- Gra, Grb, Grc, Rin, Rout, BAout  in  1 each  register-file select/read/write.
- con_ff_bit  out  1  branch condition flip-flop.
- Mem_Read, Mem_Write, Mem_enable512x32  in  1 each  memory controls.
- Mem_to_datapath_out  out  32  memory read data.
- Mem_data_to_chip_out  out  32  MDR contents (memory write data).
- MAR_address_out  out  9  MAR contents.
- mem_overide  in  1  memory override write strobe.
- overide_address  in  9  override write address.
- overide_data_in  in  32  override write data.

Behaviour:
- Reset: clear=1 at a rising edge zeroes R0-R15, PC, IR, MAR, MDR, Y, Z (64-bit), HI, LO, inport, outport and con_ff_bit. Memory contents are not cleared. clear has priority over every load.
- Bus:
  - Exactly one driver is expected per cycle.
  - If several are asserted, fixed priority: Rout/BAout > HIout > LOout > Zhi_out > Zlo_out > PCout > MDRout > Inport_out > Cout.
  - With no driver, the bus is 0.
- Instruction fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15], C IR[18:0].
- Cout drives C sign-extended from bit 18.
- Register select: Gra/Grb/Grc pick Ra/Rb/Rc; if several are asserted, they are OR-combined into one index.
  - Rin writes the bus into the selected register at the edge.
  - Rout drives the selected register.
  - BAout drives it too, except R0 reads as 0.
  - Writes to R0 are allowed.
- Loads: every xxin enable captures the bus at the rising edge. MAR keeps the low 9 bits.
- MDR mux: MDR loads memory data when Mem_Read=1, otherwise the bus.
- ALU:
  - A = Y, B = bus; result is a 64-bit value that Zin latches into Z.
  - IncPC=1 forces Zlo = bus+1 (carry ignored), Zhi = 0.
  - Opcode table:
    - 00011 add and 01100 addi: A+B.
    - 00100 sub: A-B.
    - 00101 and and 01101 andi: A&B.
    - 00110 or and 01110 ori: A|B.
    - 00111 ror, 01000 rol: rotate A by B[4:0].
    - 01001 shr, 01010 shra, 01011 shl: shift A by B[4:0].
    - 01111 mul: signed A*B, full 64 bits.
    - 10000 div: Zlo = A/B signed, Zhi = A%B. B=0 gives Z=0.
    - 10001 neg: -B.
    - 10010 not: ~B.
    - Any other opcode: A+B.
  - Single-op results go to Zlo; Zhi=0 except for mul and div.
- Memory, 512x32:
  - Read is combinational: Mem_to_datapath_out = mem[MAR] when Mem_enable512x32 && Mem_Read, else 0.
  - Write at the edge when Mem_enable512x32 && Mem_Write: mem[MAR] <= MDR.
  - Override: mem_overide=1 writes overide_data_in to overide_address at the edge. It beats a normal write to the same word.
  - Override is legal during reset.
- Fetch timing: MAR loaded at edge N lets MDR capture mem[MAR] at edge N+1 with Mem_Read=1. This is the canonical 3-cycle fetch: T0 PCout/IncPC/MARin/Zin; T1 Zlo_out/PCin/MDRin/Mem_Read; T2 MDRout/IRin.
- CON FF:
  - Loads at the edge when opcode=10011 and Rout=1, evaluating the bus value against condition IR[20:19]:
    - 00: bus==0.
    - 01: bus!=0.
    - 10: bus>0 signed.
    - 11: bus<0.
  - Otherwise it holds.
- I/O: inport loads inport_data when inport_data_ready=1; outport loads the bus when outport_in=1.

Test Plan:
- Override-write mem[0]=0x18900001 and mem[500]=0x14. Then Mem_enable/Mem_Read with MAR=500 -> Mem_to_datapath_out=0x14. MAR=0 -> 0x18900001.
- Fetch from reset: T0-T2 sequence -> MAR_address_out=0, PC=1, IR=0x18900001. A second fetch gives PC=2 and MAR=1.
- mfhi r6:
  - Setup: inport_data=0x1234 with ready; Inport_out+HIin -> HI=0x1234.
  - Fetch IR=0x03000000 (Ra=6); T3 Gra+HIout+Rin -> R6=0x1234.
- mflo r7: same flow via LOin, LO=0xABCD, IR Ra=7 -> R7=0xABCD. R6 is unchanged.
- mul then div:
  - Y=-3, bus=5, opcode 01111 -> Zhi=0xFFFFFFFF, Zlo=0xFFFFFFF1.
  - Y=20, bus=6, opcode 10000 -> Zlo=3, Zhi=2.
- clear mid-sequence after loading registers -> all registers, con_ff_bit and outport read 0 next cycle; memory retains 0x14 at address 500.
